// File: rtl/typed_fifo_pkg.sv
// Shared constants and sizing helpers for the type-parameterised FIFO.
// Used by typed_fifo and typed_fifo_mem.
package typed_fifo_pkg;

    localparam int unsigned MAX_DEPTH = 256;

    function automatic int unsigned cnt_w(int unsigned d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/typed_fifo_mem.sv
// Storage array for typed_fifo: one synchronous write port and one
// asynchronous read port, indexed by entry number.
module typed_fifo_mem
    import typed_fifo_pkg::*;
#(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  T              wdata,
    input  logic [AW-1:0] raddr,
    output T              rdata
);

    T mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/typed_fifo.sv
// Synchronous FIFO with a type-parameterised element and valid/ready on both sides.
// Define TYPED_FIFO_BYPASS_EN to let an element pass straight through an empty FIFO.
module typed_fifo
    import typed_fifo_pkg::*;
#(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4,
    parameter int  AFULL = DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$bits(T)-1:0]         in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$bits(T)-1:0]         out_data,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        almost_full,
    output logic                        overflow
);

    localparam int CW = cnt_w(DEPTH);
    localparam int W  = $bits(T);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

    if (DEPTH < 1 || DEPTH > int'(MAX_DEPTH)) begin : g_bad_depth
        $error("typed_fifo: DEPTH out of range 1..256");
    end

    logic         full;
    logic         empty;
    logic         bypass;
    logic         push;
    logic         pop;
    logic         store_push;
    logic         store_pop;
    logic [W-1:0] head_data;

    assign empty = (count == '0);

`ifdef TYPED_FIFO_BYPASS_EN
    assign bypass = empty && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready    = !full;
    assign out_valid   = !empty || bypass;
    assign out_data    = bypass ? in_data : head_data;
    assign almost_full = (count >= AFULL_C);

    // A bypassed element that is taken the same cycle never touches storage.
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign store_push = push && !(bypass && out_ready);
    assign store_pop  = pop && !bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({store_push, store_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    if (DEPTH == 1) begin : g_single
        logic [W-1:0] slot_q;
        logic         full_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                full_q <= 1'b0;
            end else if (store_push) begin
                full_q <= 1'b1;
            end else if (store_pop) begin
                full_q <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (store_push) begin
                slot_q <= in_data;
            end
        end

        assign full      = full_q;
        assign head_data = slot_q;
    end else begin : g_array
        localparam int AW = $clog2(DEPTH);
        localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
        localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

        logic [AW-1:0] wp;
        logic [AW-1:0] rp;
        logic [W-1:0]  rdata;

        // Explicit wrap so non-power-of-two depths cycle through every entry.
        always_ff @(posedge clk) begin
            if (rst) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (store_push) begin
                    wp <= (wp == LAST) ? '0 : wp + AW'(1);
                end
                if (store_pop) begin
                    rp <= (rp == LAST) ? '0 : rp + AW'(1);
                end
            end
        end

        typed_fifo_mem #(
            .T     (T),
            .DEPTH (DEPTH)
        ) u_mem (
            .clk   (clk),
            .we    (store_push),
            .waddr (wp),
            .wdata (T'(in_data)),
            .raddr (rp),
            .rdata (rdata)
        );

        assign full      = (count == DEPTH_C);
        assign head_data = rdata;
    end

endmodule
